// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: bus widths, FSM state and access op encodings.
package sram_arb_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/sram_phy.sv
// SRAM pin driver: registered control/address pins, DQ tristate and read-data capture.
// Sequenced by the arbiter FSM through load/active/last/cnt strobes.
module sram_phy
    import sram_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_load_wr,
    input  logic               i_active,
    input  logic               i_last,
    input  logic [3:0]         i_cnt,
    input  logic [SRAM_AW-1:0] i_addr,
    input  logic [SRAM_DW-1:0] i_wdata,
    input  logic [1:0]         i_be,
    output logic [SRAM_AW-1:0] o_sram_addr,
    inout  wire  [SRAM_DW-1:0] io_sram_dq,
    output logic               o_ce_n,
    output logic               o_oe_n,
    output logic               o_we_n,
    output logic               o_ub_n,
    output logic               o_lb_n,
    output logic               o_dq_oe,
    output logic               o_rd_valid,
    output logic [SRAM_DW-1:0] o_rd_data
);

    localparam logic [3:0] LAST_M1 = 4'(ACCESS_CYCLES - 1);

    op_t                r_op;
    logic [SRAM_AW-1:0] r_addr;
    logic [SRAM_DW-1:0] r_dq_out;
    logic [SRAM_DW-1:0] r_rd_data;
    logic               r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n;
    logic               r_dq_oe;
    logic               r_rd_valid;
    logic               w_capture;

    assign w_capture = i_active && i_last && (r_op == OP_RD);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op       <= OP_RD;
            r_addr     <= '0;
            r_dq_out   <= '0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_ub_n     <= 1'b1;
            r_lb_n     <= 1'b1;
            r_dq_oe    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (i_load) begin
                // The output enable and OE_N swap on the same edge; no dead cycle between ops.
                r_op    <= i_load_wr ? OP_WR : OP_RD;
                r_addr  <= i_addr;
                r_ce_n  <= 1'b0;
                r_oe_n  <= i_load_wr;
                r_we_n  <= !i_load_wr;
                r_ub_n  <= i_load_wr ? ~i_be[1] : 1'b0;
                r_lb_n  <= i_load_wr ? ~i_be[0] : 1'b0;
                r_dq_oe <= i_load_wr;
                if (i_load_wr) begin
                    r_dq_out <= i_wdata;
                end
            end else if (i_active && i_last) begin
                r_ce_n  <= 1'b1;
                r_oe_n  <= 1'b1;
                r_we_n  <= 1'b1;
                r_ub_n  <= 1'b1;
                r_lb_n  <= 1'b1;
                r_dq_oe <= 1'b0;
            end else if (i_active && (r_op == OP_WR)) begin
                // WE_N rises for the final cycle so data is held past the write strobe.
                r_we_n <= (i_cnt >= LAST_M1);
            end

            r_rd_valid <= w_capture;
            if (w_capture) begin
                r_rd_data <= io_sram_dq;
            end
        end
    end

    assign io_sram_dq  = r_dq_oe ? r_dq_out : {SRAM_DW{1'bz}};
    assign o_sram_addr = r_addr;
    assign o_ce_n      = r_ce_n;
    assign o_oe_n      = r_oe_n;
    assign o_we_n      = r_we_n;
    assign o_ub_n      = r_ub_n;
    assign o_lb_n      = r_lb_n;
    assign o_dq_oe     = r_dq_oe;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter (display read / pixel write) for a single async 256Kx16 SRAM.
// Define SRAM_ARB_STARVE_GUARD_EN to force a write grant after STARVE_LIMIT consecutive reads.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               rd_req,
    input  logic [SRAM_AW-1:0] rd_addr,
    output logic               rd_gnt,
    output logic               rd_valid,
    output logic [SRAM_DW-1:0] rd_data,
    input  logic               wr_req,
    input  logic [SRAM_AW-1:0] wr_addr,
    input  logic [SRAM_DW-1:0] wr_data,
    input  logic [1:0]         wr_be,
    output logic               wr_gnt,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               o_dbg_state
);

    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES);

    state_t             r_state, w_next_state;
    logic [3:0]         r_cnt, w_next_cnt;
    logic               w_window;
    logic               w_starve_hit;
    logic               w_gnt_rd, w_gnt_wr;
    logic               w_last;
    logic               w_dq_oe;
    logic [SRAM_AW-1:0] w_addr;

    assign w_last   = (r_state == ACCESS) && (r_cnt == LAST);
    assign w_window = (r_state == IDLE) || w_last;
    assign w_gnt_wr = w_window && wr_req && (!rd_req || w_starve_hit);
    assign w_gnt_rd = w_window && rd_req && !w_starve_hit;
    assign w_addr   = w_gnt_wr ? wr_addr : rd_addr;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int               SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]    LIMIT = SW'(STARVE_LIMIT);
    logic [SW-1:0]               r_starve_cnt;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_starve_cnt <= '0;
        end else if (w_gnt_wr || !wr_req) begin
            r_starve_cnt <= '0;
        end else if (w_gnt_rd) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    assign w_starve_hit = wr_req && (r_starve_cnt == LIMIT);
`else
    assign w_starve_hit = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (w_gnt_rd || w_gnt_wr) begin
            w_next_state = ACCESS;
            w_next_cnt   = 4'd1;
        end else if (w_window) begin
            w_next_state = IDLE;
            w_next_cnt   = 4'd0;
        end else begin
            w_next_cnt   = r_cnt + 4'd1;
        end
    end

    sram_phy #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_phy (
        .i_clk       (CLOCK_50),
        .i_rst_n     (RESET_N),
        .i_load      (w_gnt_rd || w_gnt_wr),
        .i_load_wr   (w_gnt_wr),
        .i_active    (r_state == ACCESS),
        .i_last      (w_last),
        .i_cnt       (r_cnt),
        .i_addr      (w_addr),
        .i_wdata     (wr_data),
        .i_be        (wr_be),
        .o_sram_addr (SRAM_ADDR),
        .io_sram_dq  (SRAM_DQ),
        .o_ce_n      (SRAM_CE_N),
        .o_oe_n      (SRAM_OE_N),
        .o_we_n      (SRAM_WE_N),
        .o_ub_n      (SRAM_UB_N),
        .o_lb_n      (SRAM_LB_N),
        .o_dq_oe     (w_dq_oe),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data)
    );

    assign rd_gnt      = w_gnt_rd;
    assign wr_gnt      = w_gnt_wr;
    assign o_dbg_state = r_state;

endmodule
